// File: rtl/fence_flush_sequencer.sv
// Sequences FENCE / FENCE.I / SFENCE.VMA / external D$ flush at commit:
// store drain, D$ flush handshake, then a single flush cycle for I$/TLB/pipeline.
module fence_flush_sequencer #(
  parameter int unsigned DFLUSH_TIMEOUT = 4096
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic fence_req_i,
  input  logic fence_i_req_i,
  input  logic sfence_vma_req_i,
  input  logic flush_dcache_req_i,
  input  logic no_st_pending_i,
  output logic dcache_flush_o,
  input  logic dcache_flush_ack_i,
  output logic icache_flush_o,
  output logic tlb_flush_o,
  output logic flush_pipeline_o,
  output logic busy_o,
  output logic done_o,
  output logic timeout_o
);

  localparam int unsigned CNT_W = (DFLUSH_TIMEOUT == 0) ? 1 : $clog2(DFLUSH_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((DFLUSH_TIMEOUT == 0) ? 0 : DFLUSH_TIMEOUT - 1);
  localparam bit TO_EN = (DFLUSH_TIMEOUT != 0);

  // request set bit positions: {need_d, need_i, need_tlb}
  localparam int unsigned ND = 2;
  localparam int unsigned NI = 1;
  localparam int unsigned NT = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRAIN,
    S_DFLUSH,
    S_FLUSH
  } state_e;

  state_e           state;
  logic [2:0]       active;
  logic [2:0]       deferred;
  logic [CNT_W-1:0] cnt;

  logic [2:0] req_set;
  logic [2:0] next_set;
  logic       to_hit;

  assign req_set[ND] = fence_req_i | fence_i_req_i | flush_dcache_req_i;
  assign req_set[NI] = fence_i_req_i;
  assign req_set[NT] = sfence_vma_req_i;
  assign next_set    = deferred | req_set;

  assign to_hit = TO_EN && (state == S_DFLUSH) && (cnt == TO_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= S_IDLE;
      active   <= '0;
      deferred <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|req_set) begin
            active   <= req_set;
            deferred <= '0;
            state    <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          deferred <= deferred | req_set;
          if (no_st_pending_i) begin
            cnt   <= '0;
            state <= active[ND] ? S_DFLUSH : S_FLUSH;
          end
        end
        S_DFLUSH: begin
          deferred <= deferred | req_set;
          cnt      <= cnt + 1'b1;
          if (dcache_flush_ack_i || to_hit) state <= S_FLUSH;
        end
        S_FLUSH: begin
          // requests landing in the flush cycle chain straight into the next sequence
          deferred <= '0;
          if (|next_set) begin
            active <= next_set;
            state  <= S_DRAIN;
          end else begin
            active <= '0;
            state  <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy_o           = (state != S_IDLE);
  assign dcache_flush_o   = (state == S_DFLUSH);
  assign flush_pipeline_o = (state == S_FLUSH);
  assign done_o           = (state == S_FLUSH);
  assign icache_flush_o   = (state == S_FLUSH) && active[NI];
  assign tlb_flush_o      = (state == S_FLUSH) && active[NT];
  // an ack arriving on the last allowed cycle suppresses the timeout pulse
  assign timeout_o        = to_hit && !dcache_flush_ack_i;

endmodule
